// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and small decode helpers for the
// iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> mult/div unit bundle: issue request, MTHI/MTLO writes and the
// architectural HI/LO plus status returned to the pipeline.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  // Issue handshake: StartE is the valid, !Busy is the ready; a request is
  // taken only on an edge where StartE=1 and the unit is idle, otherwise dropped.
  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             AbortE;
  logic             WrHiE;
  logic             WrLoE;
  logic [WIDTH-1:0] WrDataE;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, AbortE, WrHiE, WrLoE, WrDataE,
    input  HiOut, LoOut, Busy, Done, DivZero
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, AbortE, WrHiE, WrLoE, WrDataE,
    output HiOut, LoOut, Busy, Done, DivZero
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shifting shift-add multiply step, or a
// restoring divide step on {remainder, dividend/quotient}.
module muldiv_step #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (b_i[0] ? {1'b0, a_i} : '0);
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, b_i};
        acc_o  = acc_i;
        if (is_div_i) begin
            // Borrow out of the subtract means the divisor did not fit: restore.
            if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            else              acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end else if (FAST_MUL) begin
            acc_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, MTHI/MTLO
// writes and flush abort. Magnitudes are iterated; the sign is applied in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic   CLK,
    input  logic   RSTn,
    muldiv_if.slave bus,
    output state_e dbg_state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, raw_a_q, raw_a_d;
    logic               neg_q, neg_d, rneg_q, rneg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, divz_q, divz_d;
    logic               sgn;

    muldiv_step #(.WIDTH(WIDTH), .FAST_MUL(FAST_MUL)) u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        raw_a_d = raw_a_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        divz_d  = 1'b0;
        sgn     = op_is_signed(bus.OpE);
        prod    = neg_q ? -acc_q : acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.StartE && !bus.AbortE) begin
                    op_d    = bus.OpE;
                    a_d     = (sgn && bus.SrcAE[WIDTH-1]) ? -bus.SrcAE : bus.SrcAE;
                    b_d     = (sgn && bus.SrcBE[WIDTH-1]) ? -bus.SrcBE : bus.SrcBE;
                    neg_d   = sgn & (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
                    rneg_d  = sgn & bus.SrcAE[WIDTH-1];
                    raw_a_d = bus.SrcAE;
                    // Divide keeps the dividend in the low half and shifts quotient bits in.
                    acc_d   = op_is_div(bus.OpE) ? {{WIDTH{1'b0}}, a_d} : '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (!bus.StartE) begin
                    if (bus.WrHiE) hi_d = bus.WrDataE;
                    if (bus.WrLoE) lo_d = bus.WrDataE;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                if (!op_is_div(op_q)) b_d = b_q >> 1;
                if (cnt_q == CW'(WIDTH - 1) || (FAST_MUL && !op_is_div(op_q))) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!op_is_div(op_q)) begin
                    {hi_d, lo_d} = prod;
                end else if (b_q == '0) begin
                    lo_d   = '1;
                    hi_d   = raw_a_q;
                    divz_d = 1'b1;
                end else begin
                    lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.AbortE && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            divz_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            raw_a_q <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            raw_a_q <= raw_a_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign bus.HiOut    = hi_q;
    assign bus.LoOut    = lo_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.DivZero  = divz_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an iterative and a fast-multiply instance driven in
// lockstep, checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_e = 0, abort_e = 0, wr_hi_e = 0, wr_lo_e = 0;
  logic [1:0]   op_e = 0;
  logic [W-1:0] src_a = 0, src_b = 0, wr_data = 0;
  state_e       st_s, st_f;

  muldiv_if #(.WIDTH(W)) if_s ();
  muldiv_if #(.WIDTH(W)) if_f ();

  assign if_s.StartE = start_e;  assign if_f.StartE = start_e;
  assign if_s.OpE = op_e;        assign if_f.OpE = op_e;
  assign if_s.SrcAE = src_a;     assign if_f.SrcAE = src_a;
  assign if_s.SrcBE = src_b;     assign if_f.SrcBE = src_b;
  assign if_s.AbortE = abort_e;  assign if_f.AbortE = abort_e;
  assign if_s.WrHiE = wr_hi_e;   assign if_f.WrHiE = wr_hi_e;
  assign if_s.WrLoE = wr_lo_e;   assign if_f.WrLoE = wr_lo_e;
  assign if_s.WrDataE = wr_data; assign if_f.WrDataE = wr_data;

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) u_slow (
    .CLK(clk), .RSTn(rst_n), .bus(if_s), .dbg_state_o(st_s));
  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
    .CLK(clk), .RSTn(rst_n), .bus(if_f), .dbg_state_o(st_f));

  int n_checks = 0;
  int n_fail = 0;
  logic [2*W:0] exp_q[$];

  task automatic chk(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div_by_zero, HI, LO} from plain signed/unsigned arithmetic.
  function automatic logic [2*W:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    logic [W-1:0]    q, r;
    sa = a;
    sb = b;
    if (op == OP_MULT) begin
      p = longint'(sa) * longint'(sb);
      return {1'b0, 64'(p)};
    end
    if (op == OP_MULTU) begin
      pu = 64'(a) * 64'(b);
      return {1'b0, pu};
    end
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (op == OP_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, a};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, r, q};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op on both units, track Done/latency, then score the result.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W:0] exp;
    int lat_s = 0, lat_f = 0, np_f = 0, gaps = 0;
    logic dz_s = 0, dz_f = 0;
    exp_q.push_back(ref_model(op, a, b));
    start_e = 1; op_e = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start_e = 0; op_e = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
    for (int k = 1; k <= 40 && lat_s == 0; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin start_e = 0; wr_hi_e = 0; wr_lo_e = 0; end
      if (if_s.Done) begin lat_s = k; dz_s = if_s.DivZero; end
      else if (!if_s.Busy) gaps++;
      if (if_f.Done) begin np_f++; if (lat_f == 0) lat_f = k; dz_f = if_f.DivZero; end
      if (k == 5 && op[1]) begin
        start_e = 1; op_e = 2'($urandom_range(0, 3));
        wr_hi_e = 1; wr_lo_e = 1; wr_data = $urandom;
      end
    end
    exp = exp_q.pop_front();
    chk("latency_slow", 65'(lat_s), 65'(W + 1));
    chk("latency_fast", 65'(lat_f), op[1] ? 65'(W + 1) : 65'd2);
    chk("done_pulses_fast", 65'(np_f), 65'd1);
    chk("busy_gaps", 65'(gaps), 65'd0);
    chk("busy_at_done", 65'(if_s.Busy), 65'd0);
    chk("result_slow", {dz_s, if_s.HiOut, if_s.LoOut}, exp);
    chk("result_fast", {dz_f, if_f.HiOut, if_f.LoOut}, exp);
  endtask

  initial begin
    int done_seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 65'(if_s.Busy), 65'd0);
    chk("rst_done", 65'({if_s.Done, if_s.DivZero}), 65'd0);
    chk("rst_hilo", {1'b0, if_s.HiOut, if_s.LoOut}, 65'd0);
    chk("rst_state", 65'(st_s), 65'(ST_IDLE));
    rst_n = 1;
    @(posedge clk); #1;

    wr_hi_e = 1; wr_data = 32'h11;
    @(posedge clk); #1;
    chk("mthi", 65'(if_s.HiOut), 65'h11);
    wr_hi_e = 0; wr_lo_e = 1; wr_data = 32'h22;
    @(posedge clk); #1;
    chk("mtlo", 65'(if_s.LoOut), 65'h22);
    wr_lo_e = 0;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_ff", {1'b0, if_s.HiOut, if_s.LoOut}, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    run_op(OP_MULT, -32'sd3, 32'd7);
    chk("mult_m3x7", {1'b0, if_s.HiOut, if_s.LoOut}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(OP_DIV, -32'sd7, 32'd2);
    chk("div_m7d2", {1'b0, if_s.HiOut, if_s.LoOut}, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(OP_DIVU, 32'd7, 32'd0);
    chk("divu_by0", {1'b0, if_s.HiOut, if_s.LoOut}, {1'b0, 32'h7, 32'hFFFF_FFFF});
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {1'b0, if_s.HiOut, if_s.LoOut}, {1'b0, 32'h0, 32'h8000_0000});

    // Asynchronous reset in the middle of a divide, away from any clock edge.
    start_e = 1; op_e = OP_DIV; src_a = 32'd1000; src_b = 32'd7;
    @(posedge clk); #1;
    start_e = 0;
    repeat (10) @(posedge clk);
    #4;
    rst_n = 0;
    #1;
    chk("arst_busy", 65'({if_s.Busy, if_f.Busy}), 65'd0);
    chk("arst_hilo_s", {1'b0, if_s.HiOut, if_s.LoOut}, 65'd0);
    chk("arst_hilo_f", {1'b0, if_f.HiOut, if_f.LoOut}, 65'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("arst_idle", 65'(st_s), 65'(ST_IDLE));
    chk("arst_busy_after", 65'(if_s.Busy), 65'd0);

    // Preload, then start a divide with a coincident MTHI that must lose.
    wr_hi_e = 1; wr_lo_e = 1; wr_data = 32'h11;
    @(posedge clk); #1;
    wr_hi_e = 0; wr_data = 32'h22;
    @(posedge clk); #1;
    wr_lo_e = 0;
    start_e = 1; op_e = OP_DIV; src_a = 32'd12345; src_b = 32'd3;
    wr_hi_e = 1; wr_data = 32'h55;
    @(posedge clk); #1;
    start_e = 0; wr_hi_e = 0;
    done_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (if_s.Done) done_seen++;
      if (k == 3) begin wr_hi_e = 1; wr_data = 32'h99; end
      if (k == 4) wr_hi_e = 0;
      if (k == 5) begin start_e = 1; op_e = OP_MULTU; end
      if (k == 6) start_e = 0;
    end
    chk("busy_before_abort", 65'(if_s.Busy), 65'd1);
    abort_e = 1;
    @(posedge clk); #1;
    abort_e = 0;
    chk("abort_busy", 65'({if_s.Busy, if_f.Busy}), 65'd0);
    chk("abort_hilo", {1'b0, if_s.HiOut, if_s.LoOut}, {1'b0, 32'h11, 32'h22});
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (if_s.Done || if_f.Done || if_s.Busy) done_seen++;
    end
    chk("abort_no_done", 65'(done_seen), 65'd0);
    chk("abort_hilo_late", {1'b0, if_f.HiOut, if_f.LoOut}, {1'b0, 32'h11, 32'h22});

    for (int i = 0; i < 50; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
